regfile_rename: RTL and testbench

REGFILE_RENAME -- requirements
Module: regfile_rename

---
 rtl/regfile_rename.sv | 115 +++++++++++
 tb/tb_regfile_rename.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_rename.sv
// rtl/regfile_rename.sv - architectural register file with rename busy/tag tracking and commit bypass
module regfile_rename #(
    parameter int REG_CARD_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int ROB_TAG_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      issue_en,
    input  logic [REG_CARD_WIDTH-1:0] issue_rd,
    input  logic [ROB_TAG_WIDTH-1:0]  issue_tag,
    input  logic                      commit_en,
    input  logic [REG_CARD_WIDTH-1:0] commit_rd,
    input  logic [ROB_TAG_WIDTH-1:0]  commit_tag,
    input  logic [DATA_WIDTH-1:0]     commit_data,
    input  logic [REG_CARD_WIDTH-1:0] rs1,
    input  logic [REG_CARD_WIDTH-1:0] rs2,
    output logic [DATA_WIDTH-1:0]     rs1_data,
    output logic [DATA_WIDTH-1:0]     rs2_data,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic [ROB_TAG_WIDTH-1:0]  rs1_tag,
    output logic [ROB_TAG_WIDTH-1:0]  rs2_tag
);

    localparam int DEPTH = 2 ** REG_CARD_WIDTH;

    logic [DATA_WIDTH-1:0]    value_q [DEPTH];
    logic [DATA_WIDTH-1:0]    value_d [DEPTH];
    logic [ROB_TAG_WIDTH-1:0] tag_q   [DEPTH];
    logic [ROB_TAG_WIDTH-1:0] tag_d   [DEPTH];
    logic [DEPTH-1:0]         busy_q;
    logic [DEPTH-1:0]         busy_d;

    // Index 0 is hardwired to zero, so nothing ever targets it.
    logic commit_live;
    logic issue_live;
    logic commit_clears;

    assign commit_live   = commit_en && (|commit_rd);
    assign issue_live    = issue_en && (|issue_rd) && !flush;
    assign commit_clears = commit_live && busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag);

    // Next-state: commit writes first, then a flush wipes busy or an issue renames (issue overrides commit).
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        if (commit_live) begin
            value_d[commit_rd] = commit_data;
            if (commit_clears) begin
                busy_d[commit_rd] = 1'b0;
            end
        end
        if (flush) begin
            busy_d = '0;
        end else if (issue_live) begin
            busy_d[issue_rd] = 1'b1;
            tag_d[issue_rd]  = issue_tag;
        end
    end

    // State registers; reset clears everything asynchronously so pending renames are dropped at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
            busy_q  <= busy_d;
        end
    end

    // Read port 1: stored state with commit data/busy-clear bypassed in the same cycle.
    always_comb begin
        rs1_data = value_q[rs1];
        rs1_busy = busy_q[rs1];
        rs1_tag  = tag_q[rs1];
        if (commit_live && (commit_rd == rs1)) begin
            rs1_data = commit_data;
            if (commit_clears) begin
                rs1_busy = 1'b0;
            end
        end
        if (~|rs1) begin
            rs1_data = '0;
            rs1_busy = 1'b0;
            rs1_tag  = '0;
        end
    end

    // Read port 2: identical to port 1, fully independent.
    always_comb begin
        rs2_data = value_q[rs2];
        rs2_busy = busy_q[rs2];
        rs2_tag  = tag_q[rs2];
        if (commit_live && (commit_rd == rs2)) begin
            rs2_data = commit_data;
            if (commit_clears) begin
                rs2_busy = 1'b0;
            end
        end
        if (~|rs2) begin
            rs2_data = '0;
            rs2_busy = 1'b0;
            rs2_tag  = '0;
        end
    end

endmodule

// File: tb/tb_regfile_rename.sv
// tb/tb_regfile_rename.sv - randomized and directed checks of regfile_rename against a behavioural model
module tb_regfile_rename;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_tag;
    logic        commit_en;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_tag;
    logic [31:0] commit_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [3:0]  rs1_tag;
    logic [3:0]  rs2_tag;

    int n_checks;
    int n_errors;

    // Reference state: what each architectural register holds according to the rename rules.
    logic [31:0] m_val  [32];
    bit          m_busy [32];
    logic [3:0]  m_tag  [32];

    regfile_rename dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .issue_tag   (issue_tag),
        .commit_en   (commit_en),
        .commit_rd   (commit_rd),
        .commit_tag  (commit_tag),
        .commit_data (commit_data),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rs1_tag     (rs1_tag),
        .rs2_tag     (rs2_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    function automatic bit commit_hits(input logic [4:0] r);
        return commit_en && (commit_rd == r) && (r != 5'd0);
    endfunction

    task automatic check_port(input string p, input logic [4:0] r,
                              input logic [31:0] d, input logic b, input logic [3:0] t);
        logic [31:0] ed;
        bit          eb;
        ed = commit_hits(r) ? commit_data : m_val[r];
        eb = m_busy[r] && !(commit_hits(r) && m_tag[r] == commit_tag);
        check({p, "_data"}, {32'd0, d}, {32'd0, ed});
        check({p, "_busy"}, {63'd0, b}, {63'd0, eb});
        check({p, "_tag"},  {60'd0, t}, {60'd0, m_tag[r]});
    endtask

    task automatic model_update();
        bit clr;
        if (!rst) begin
            model_reset();
            return;
        end
        if (commit_en && commit_rd != 5'd0) begin
            clr = m_busy[commit_rd] && (m_tag[commit_rd] == commit_tag);
            m_val[commit_rd] = commit_data;
            if (clr) m_busy[commit_rd] = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (issue_en && issue_rd != 5'd0) begin
            m_busy[issue_rd] = 1'b1;
            m_tag[issue_rd]  = issue_tag;
        end
    endtask

    // One clock: compare both read ports mid-cycle, then advance the model on the edge.
    task automatic step();
        @(negedge clk);
        if (!rst) model_reset();
        check_port("rs1", rs1, rs1_data, rs1_busy, rs1_tag);
        check_port("rs2", rs2, rs2_data, rs2_busy, rs2_tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        flush     = 1'b0;
        issue_en  = 1'b0;
        commit_en = 1'b0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [3:0] t);
        issue_en = 1'b1; issue_rd = rd; issue_tag = t;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [3:0] t, input logic [31:0] d);
        commit_en = 1'b1; commit_rd = rd; commit_tag = t; commit_data = d;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst = 1'b0;
        idle();
        issue_rd = '0; issue_tag = '0; commit_rd = '0; commit_tag = '0; commit_data = '0;
        rs1 = 5'd5; rs2 = 5'd31;
        step();
        step();
        rst = 1'b1;

        // Reset state and index 0 immunity
        #1;
        check("rst_d1", {32'd0, rs1_data}, 64'd0);
        check("rst_b2", {63'd0, rs2_busy}, 64'd0);
        do_issue(5'd0, 4'd3);
        step();
        idle(); rs1 = 5'd0; #1;
        check("x0_busy", {63'd0, rs1_busy}, 64'd0);
        check("x0_data", {32'd0, rs1_data}, 64'd0);
        step();

        // Issue then matching commit with same-cycle bypass
        do_issue(5'd7, 4'd2); step();
        idle(); rs1 = 5'd7; #1;
        check("r7_busy", {63'd0, rs1_busy}, 64'd1);
        check("r7_tag", {60'd0, rs1_tag}, 64'd2);
        do_commit(5'd7, 4'd2, 32'hDEADBEEF); #1;
        check("r7_byp_data", {32'd0, rs1_data}, 64'hDEADBEEF);
        check("r7_byp_busy", {63'd0, rs1_busy}, 64'd0);
        step(); idle(); #1;
        check("r7_after_busy", {63'd0, rs1_busy}, 64'd0);
        check("r7_after_data", {32'd0, rs1_data}, 64'hDEADBEEF);

        // Stale commit must not clear the younger rename
        do_issue(5'd3, 4'd1); step();
        do_issue(5'd3, 4'd4); step();
        idle(); do_commit(5'd3, 4'd1, 32'h11); step();
        idle(); rs1 = 5'd3; #1;
        check("r3_data", {32'd0, rs1_data}, 64'h11);
        check("r3_busy", {63'd0, rs1_busy}, 64'd1);
        check("r3_tag", {60'd0, rs1_tag}, 64'd4);
        do_commit(5'd3, 4'd4, 32'h22); step();
        idle(); #1;
        check("r3_busy2", {63'd0, rs1_busy}, 64'd0);
        check("r3_data2", {32'd0, rs1_data}, 64'h22);

        // Issue wins over same-cycle commit on the same register
        do_issue(5'd9, 4'd5); step();
        do_commit(5'd9, 4'd5, 32'h99); do_issue(5'd9, 4'd6); step();
        idle(); rs1 = 5'd9; #1;
        check("r9_busy", {63'd0, rs1_busy}, 64'd1);
        check("r9_tag", {60'd0, rs1_tag}, 64'd6);
        check("r9_data", {32'd0, rs1_data}, 64'h99);

        // Flush with same-cycle commit and issue
        do_issue(5'd1, 4'd1); step();
        do_issue(5'd2, 4'd2); step();
        do_issue(5'd3, 4'd3); step();
        flush = 1'b1; do_commit(5'd2, 4'd2, 32'h55); do_issue(5'd4, 4'd7); step();
        idle(); rs1 = 5'd2; rs2 = 5'd4; #1;
        check("fl_r2_data", {32'd0, rs1_data}, 64'h55);
        check("fl_r2_busy", {63'd0, rs1_busy}, 64'd0);
        check("fl_r4_busy", {63'd0, rs2_busy}, 64'd0);
        rs1 = 5'd1; rs2 = 5'd3; #1;
        check("fl_r1_busy", {63'd0, rs1_busy}, 64'd0);
        check("fl_r3_busy", {63'd0, rs2_busy}, 64'd0);

        // Asynchronous reset mid-cycle drops pending rename
        do_issue(5'd10, 4'd8); step();
        idle(); do_commit(5'd10, 4'd0, 32'hAB); step();
        idle(); rs1 = 5'd10; #1;
        check("r10_data", {32'd0, rs1_data}, 64'hAB);
        check("r10_busy", {63'd0, rs1_busy}, 64'd1);
        rst = 1'b0; #1;
        check("arst_data", {32'd0, rs1_data}, 64'd0);
        check("arst_busy", {63'd0, rs1_busy}, 64'd0);
        check("arst_tag", {60'd0, rs1_tag}, 64'd0);
        step();
        rst = 1'b1;
        do_commit(5'd10, 4'd8, 32'h0); step();
        idle(); #1;
        check("r10_post_busy", {63'd0, rs1_busy}, 64'd0);

        // Randomized traffic over a small register window to force collisions
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] crd;
            rst       = ($urandom_range(0, 299) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            issue_en  = $urandom_range(0, 1);
            issue_rd  = 5'($urandom_range(0, 7));
            issue_tag = 4'($urandom);
            commit_en = $urandom_range(0, 1);
            crd       = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            commit_rd = crd;
            commit_tag = $urandom_range(0, 1) ? m_tag[crd] : 4'($urandom);
            commit_data = $urandom;
            rs1 = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'($urandom_range(0, 7));
            rs2 = $urandom_range(0, 3) == 0 ? rs1 : 5'($urandom_range(0, 7));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
